bcd_cnt_999: RTL and testbench



---
 rtl/bcd_pkg.sv | 68 ++++++
 rtl/bcd_cnt_999_seg7_dec.sv | 21 ++
 rtl/bcd_cnt_999.sv | 150 +++++++++++++++
 tb/tb_bcd_cnt_999.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared types, segment patterns and BCD arithmetic helpers for the
// three-digit BCD counter.
//   bcd_digit_t  : one BCD nibble (0..9 when legal)
//   seg7_t       : active-low seven-segment pattern, bit order {g,f,e,d,c,b,a}
//   SEG_BLANK    : all segments off
//   SEG_DIGIT    : active-low patterns for digits 0..9
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;
    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_BLANK = 7'b1111111;

    localparam seg7_t SEG_DIGIT [0:9] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000   // 9
    };

    // True when every nibble of a three-digit BCD word is a legal digit.
    function automatic logic bcd_is_valid(input logic [11:0] v);
        return (v[11:8] <= 4'd9) && (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    // Three-digit BCD increment; 999 rolls to 000.
    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        if (v[3:0] == 4'd9) begin
            r[3:0] = 4'd0;
            if (v[7:4] == 4'd9) begin
                r[7:4]  = 4'd0;
                r[11:8] = (v[11:8] == 4'd9) ? 4'd0 : v[11:8] + 4'd1;
            end else begin
                r[7:4] = v[7:4] + 4'd1;
            end
        end else begin
            r[3:0] = v[3:0] + 4'd1;
        end
        return r;
    endfunction

    // Three-digit BCD decrement; 000 rolls to 999.
    function automatic logic [11:0] bcd_dec(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        if (v[3:0] == 4'd0) begin
            r[3:0] = 4'd9;
            if (v[7:4] == 4'd0) begin
                r[7:4]  = 4'd9;
                r[11:8] = (v[11:8] == 4'd0) ? 4'd9 : v[11:8] - 4'd1;
            end else begin
                r[7:4] = v[7:4] - 4'd1;
            end
        end else begin
            r[3:0] = v[3:0] - 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_cnt_999_seg7_dec.sv
// seg7_dec: combinational BCD digit to active-low seven-segment decoder.
//   digit : BCD nibble to display
//   blank : 1 forces all segments off
//   seg   : active-low segments {g..a}
// An illegal nibble (>9) shows blank rather than garbage.
module seg7_dec
    import bcd_pkg::*;
(
    input  bcd_digit_t digit,
    input  logic       blank,
    output seg7_t      seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank && (digit <= 4'd9)) begin
            seg = SEG_DIGIT[digit];
        end
    end

endmodule

// File: rtl/bcd_cnt_999.sv
// bcd_cnt_999: three-digit BCD counter (000..999) advanced by the rising edge
// of a slow divided clock that is sampled as data in the clk_in domain.
//   clk_in    : board clock, the only clock
//   rst       : asynchronous active-low reset
//   step_in   : divided clock, synchronised and rising-edge detected
//   en        : count enable, only looked at when a step occurs
//   up_dn     : 1 = up, 0 = down
//   clr       : synchronous clear to 000 (highest priority)
//   load      : synchronous load of load_val (rejected if any nibble > 9)
//   load_val  : BCD {hundreds, tens, ones}
//   bcd       : current count {hundreds, tens, ones}
//   tc        : one-cycle pulse after a step taken at the limit (999 up / 000 down)
//   load_err  : one-cycle pulse after a rejected load
//   hex0..2   : registered active-low segments for ones/tens/hundreds
// Parameters: WRAP (1 = wrap at the limit, 0 = saturate), BLANK_LZ (1 = blank
// leading zeros on hex2/hex1; hex0 is always shown).
module bcd_cnt_999
    import bcd_pkg::*;
#(
    parameter bit WRAP     = 1'b1,
    parameter bit BLANK_LZ = 1'b0
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        step_in,
    input  logic        en,
    input  logic        up_dn,
    input  logic        clr,
    input  logic        load,
    input  logic [11:0] load_val,
    output logic [11:0] bcd,
    output logic        tc,
    output logic        load_err,
    output seg7_t       hex0,
    output seg7_t       hex1,
    output seg7_t       hex2
);

    // Value shown on hex1/hex2 while the count is 000.
    localparam seg7_t LZ_RST = BLANK_LZ ? SEG_BLANK : SEG_DIGIT[0];

    // Synchroniser and edge detect. All three flops reset high so a step_in
    // that is already high when reset releases is not seen as a rising edge.
    logic sync1, sync2, prev;
    logic step;

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            prev  <= 1'b1;
        end else begin
            sync1 <= step_in;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign step = sync2 & ~prev;

    // Counter next-state: clr > load > (step & en); lower-priority events in
    // the same cycle are dropped.
    logic [11:0] bcd_q, bcd_nxt;
    logic        tc_q, tc_nxt;
    logic        err_q, err_nxt;
    logic        at_max, at_min;

    assign at_max = (bcd_q == 12'h999);
    assign at_min = (bcd_q == 12'h000);

    always_comb begin
        bcd_nxt = bcd_q;
        tc_nxt  = 1'b0;
        err_nxt = 1'b0;
        if (clr) begin
            bcd_nxt = 12'h000;
        end else if (load) begin
            if (bcd_is_valid(load_val)) begin
                bcd_nxt = load_val;
            end else begin
                err_nxt = 1'b1;
            end
        end else if (step && en) begin
            if (up_dn) begin
                if (at_max) begin
                    tc_nxt = 1'b1;
                    if (WRAP) begin
                        bcd_nxt = 12'h000;
                    end
                end else begin
                    bcd_nxt = bcd_inc(bcd_q);
                end
            end else begin
                if (at_min) begin
                    tc_nxt = 1'b1;
                    if (WRAP) begin
                        bcd_nxt = 12'h999;
                    end
                end else begin
                    bcd_nxt = bcd_dec(bcd_q);
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            bcd_q <= 12'h000;
            tc_q  <= 1'b0;
            err_q <= 1'b0;
        end else begin
            bcd_q <= bcd_nxt;
            tc_q  <= tc_nxt;
            err_q <= err_nxt;
        end
    end

    // Segment decode of the current count; registered one edge behind bcd.
    logic  blank_hund, blank_tens;
    seg7_t seg_ones, seg_tens, seg_hund;

    assign blank_hund = BLANK_LZ && (bcd_q[11:8] == 4'd0);
    assign blank_tens = BLANK_LZ && (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0);

    seg7_dec u_dec_ones (.digit(bcd_q[3:0]),  .blank(1'b0),       .seg(seg_ones));
    seg7_dec u_dec_tens (.digit(bcd_q[7:4]),  .blank(blank_tens), .seg(seg_tens));
    seg7_dec u_dec_hund (.digit(bcd_q[11:8]), .blank(blank_hund), .seg(seg_hund));

    seg7_t hex0_q, hex1_q, hex2_q;

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            hex0_q <= SEG_DIGIT[0];
            hex1_q <= LZ_RST;
            hex2_q <= LZ_RST;
        end else begin
            hex0_q <= seg_ones;
            hex1_q <= seg_tens;
            hex2_q <= seg_hund;
        end
    end

    assign bcd      = bcd_q;
    assign tc       = tc_q;
    assign load_err = err_q;
    assign hex0     = hex0_q;
    assign hex1     = hex1_q;
    assign hex2     = hex2_q;

endmodule

// File: tb/tb_bcd_cnt_999.sv
// Bench for bcd_cnt_999. Two instances share all inputs:
//   dut_a : WRAP=1, BLANK_LZ=0
//   dut_b : WRAP=0, BLANK_LZ=1
// Expected values come from hand-written constants and a small integer model.
module tb_bcd_cnt_999;

    logic        clk_in = 1'b0;
    logic        rst;
    logic        step_in;
    logic        en;
    logic        up_dn;
    logic        clr;
    logic        load;
    logic [11:0] load_val;

    logic [11:0] bcd_a, bcd_b;
    logic        tc_a, tc_b, err_a, err_b;
    logic [6:0]  hex0_a, hex1_a, hex2_a, hex0_b, hex1_b, hex2_b;

    int n_tests = 0;
    int n_fail  = 0;

    logic [6:0] seg_tab [0:9];

    // ---------------- clock ----------------
    always #5 clk_in = ~clk_in;

    bcd_cnt_999 #(.WRAP(1'b1), .BLANK_LZ(1'b0)) dut_a (
        .clk_in(clk_in), .rst(rst), .step_in(step_in), .en(en), .up_dn(up_dn),
        .clr(clr), .load(load), .load_val(load_val),
        .bcd(bcd_a), .tc(tc_a), .load_err(err_a),
        .hex0(hex0_a), .hex1(hex1_a), .hex2(hex2_a)
    );

    bcd_cnt_999 #(.WRAP(1'b0), .BLANK_LZ(1'b1)) dut_b (
        .clk_in(clk_in), .rst(rst), .step_in(step_in), .en(en), .up_dn(up_dn),
        .clr(clr), .load(load), .load_val(load_val),
        .bcd(bcd_b), .tc(tc_b), .load_err(err_b),
        .hex0(hex0_b), .hex1(hex1_b), .hex2(hex2_b)
    );

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %03h expected %03h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int n);
        return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    // Checks all six hex outputs against the bench's own segment table.
    task automatic check_hex(input string tag, input logic [11:0] va, input logic [11:0] vb);
        logic [6:0] e1b, e2b;
        check_eq({tag, "_hex0_a"}, 12'(hex0_a), 12'(seg_tab[va[3:0]]));
        check_eq({tag, "_hex1_a"}, 12'(hex1_a), 12'(seg_tab[va[7:4]]));
        check_eq({tag, "_hex2_a"}, 12'(hex2_a), 12'(seg_tab[va[11:8]]));
        e2b = (vb[11:8] == 4'd0) ? 7'h7F : seg_tab[vb[11:8]];
        e1b = (vb[11:8] == 4'd0 && vb[7:4] == 4'd0) ? 7'h7F : seg_tab[vb[7:4]];
        check_eq({tag, "_hex0_b"}, 12'(hex0_b), 12'(seg_tab[vb[3:0]]));
        check_eq({tag, "_hex1_b"}, 12'(hex1_b), 12'(e1b));
        check_eq({tag, "_hex2_b"}, 12'(hex2_b), 12'(e2b));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_bcd_a"}, bcd_a, 12'h000);
        check_eq({tag, "_bcd_b"}, bcd_b, 12'h000);
        check_eq({tag, "_tc_a"},  12'(tc_a), 12'h0);
        check_eq({tag, "_tc_b"},  12'(tc_b), 12'h0);
        check_eq({tag, "_err_a"}, 12'(err_a), 12'h0);
        check_eq({tag, "_err_b"}, 12'(err_b), 12'h0);
        check_eq({tag, "_hex0_a"}, 12'(hex0_a), 12'h040);
        check_eq({tag, "_hex1_a"}, 12'(hex1_a), 12'h040);
        check_eq({tag, "_hex2_a"}, 12'(hex2_a), 12'h040);
        check_eq({tag, "_hex0_b"}, 12'(hex0_b), 12'h040);
        check_eq({tag, "_hex1_b"}, 12'(hex1_b), 12'h07F);
        check_eq({tag, "_hex2_b"}, 12'(hex2_b), 12'h07F);
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_load(input logic [11:0] v);
        load_val = v;
        load     = 1'b1;
        tick;
        load     = 1'b0;
    endtask

    // step_in high across two edges (k, k+1): bcd/tc update at k+2, hex at k+3.
    task automatic do_step(input string tag, input logic [11:0] ea, input logic [11:0] eb,
                           input logic tca, input logic tcb);
        step_in = 1'b1;
        tick;
        tick;
        step_in = 1'b0;
        tick;
        check_eq({tag, "_bcd_a"}, bcd_a, ea);
        check_eq({tag, "_bcd_b"}, bcd_b, eb);
        check_eq({tag, "_tc_a"}, 12'(tc_a), 12'(tca));
        check_eq({tag, "_tc_b"}, 12'(tc_b), 12'(tcb));
        tick;
        check_eq({tag, "_tc_a_low"}, 12'(tc_a), 12'h0);
        check_eq({tag, "_tc_b_low"}, 12'(tc_b), 12'h0);
        check_hex(tag, ea, eb);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        seg_tab[0] = 7'h40; seg_tab[1] = 7'h79; seg_tab[2] = 7'h24; seg_tab[3] = 7'h30;
        seg_tab[4] = 7'h19; seg_tab[5] = 7'h12; seg_tab[6] = 7'h02; seg_tab[7] = 7'h78;
        seg_tab[8] = 7'h00; seg_tab[9] = 7'h10;

        rst = 1'b0; step_in = 1'b1; en = 1'b1; up_dn = 1'b1;
        clr = 1'b0; load = 1'b0; load_val = 12'h000;
        repeat (3) tick;
        check_reset_outputs("in_reset");

        // Release with step_in held high: no edge must be seen.
        rst = 1'b1;
        repeat (5) tick;
        check_reset_outputs("post_reset_high");
        step_in = 1'b0;
        repeat (3) tick;
        check_eq("idle_bcd_a", bcd_a, 12'h000);

        // Full up count, 1000 steps.
        for (int i = 1; i <= 1000; i++) begin
            do_step("up", to_bcd(i % 1000), to_bcd((i == 1000) ? 999 : i),
                    (i == 1000), (i == 1000));
        end

        // Down at 000: dut_a wraps to 999, dut_b saturates with tc each step.
        clr = 1'b1;
        tick;
        clr = 1'b0;
        check_eq("clr_bcd_a", bcd_a, 12'h000);
        check_eq("clr_bcd_b", bcd_b, 12'h000);
        up_dn = 1'b0;
        do_step("dn_lim1", 12'h999, 12'h000, 1'b1, 1'b1);
        do_step("dn_lim2", 12'h998, 12'h000, 1'b0, 1'b1);

        // Rejected loads.
        do_load(12'h1A3);
        check_eq("ld1a3_bcd_a", bcd_a, 12'h998);
        check_eq("ld1a3_bcd_b", bcd_b, 12'h000);
        check_eq("ld1a3_err_a", 12'(err_a), 12'h1);
        check_eq("ld1a3_err_b", 12'(err_b), 12'h1);
        tick;
        check_eq("ld1a3_err_a_low", 12'(err_a), 12'h0);
        do_load(12'h90A);
        check_eq("ld90a_bcd_a", bcd_a, 12'h998);
        check_eq("ld90a_err_b", 12'(err_b), 12'h1);
        tick;

        // Accepted load, leading-zero blanking.
        do_load(12'h099);
        check_eq("ld099_bcd_a", bcd_a, 12'h099);
        check_eq("ld099_bcd_b", bcd_b, 12'h099);
        check_eq("ld099_err_a", 12'(err_a), 12'h0);
        tick;
        check_hex("ld099", 12'h099, 12'h099);

        // Borrow across two digits.
        do_load(12'h500);
        do_step("dn_borrow", 12'h499, 12'h499, 1'b0, 1'b0);
        do_step("dn_plain", 12'h498, 12'h498, 1'b0, 1'b0);

        // Enable low: step ignored.
        en = 1'b0;
        do_step("en0", 12'h498, 12'h498, 1'b0, 1'b0);
        en = 1'b1;

        // clr + load + step at a limit in one cycle: clr wins, no tc.
        up_dn = 1'b1;
        do_load(12'h999);
        step_in = 1'b1;
        tick;
        tick;
        step_in = 1'b0; clr = 1'b1; load = 1'b1; load_val = 12'h555;
        tick;
        clr = 1'b0; load = 1'b0;
        check_eq("prio_clr_bcd_a", bcd_a, 12'h000);
        check_eq("prio_clr_bcd_b", bcd_b, 12'h000);
        check_eq("prio_clr_tc_a", 12'(tc_a), 12'h0);
        check_eq("prio_clr_tc_b", 12'(tc_b), 12'h0);
        check_eq("prio_clr_err_a", 12'(err_a), 12'h0);
        tick;

        // load + step at a limit: load wins, no tc.
        do_load(12'h999);
        step_in = 1'b1;
        tick;
        tick;
        step_in = 1'b0; load = 1'b1; load_val = 12'h555;
        tick;
        load = 1'b0;
        check_eq("prio_ld_bcd_a", bcd_a, 12'h555);
        check_eq("prio_ld_tc_a", 12'(tc_a), 12'h0);
        check_eq("prio_ld_tc_b", 12'(tc_b), 12'h0);
        tick;

        // Rejected load + step: step still dropped.
        step_in = 1'b1;
        tick;
        tick;
        step_in = 1'b0; load = 1'b1; load_val = 12'h5B5;
        tick;
        load = 1'b0;
        check_eq("prio_bad_bcd_a", bcd_a, 12'h555);
        check_eq("prio_bad_err_a", 12'(err_a), 12'h1);
        check_eq("prio_bad_tc_a", 12'(tc_a), 12'h0);
        tick;

        // Latency: edge k samples step_in, bcd at k+2, hex0 at k+3.
        step_in = 1'b1;
        tick;
        check_eq("lat_k_bcd", bcd_a, 12'h555);
        tick;
        check_eq("lat_k1_bcd", bcd_a, 12'h555);
        step_in = 1'b0;
        tick;
        check_eq("lat_k2_bcd", bcd_a, 12'h556);
        check_eq("lat_k2_hex0", 12'(hex0_a), 12'(seg_tab[5]));
        tick;
        check_eq("lat_k3_hex0", 12'(hex0_a), 12'(seg_tab[6]));

        // Asynchronous reset while tc is high and the display shows 999.
        do_load(12'h999);
        step_in = 1'b1;
        tick;
        tick;
        step_in = 1'b0;
        tick;
        check_eq("pre_rst_tc_a", 12'(tc_a), 12'h1);
        check_eq("pre_rst_bcd_b", bcd_b, 12'h999);
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("async_rst");

        // Reset with a pending step: step is lost.
        tick;
        rst = 1'b1;
        do_load(12'h777);
        step_in = 1'b1;
        tick;
        tick;
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("rst_pending");
        tick;
        rst = 1'b1;
        repeat (4) tick;
        check_eq("rst_pending_bcd_a", bcd_a, 12'h000);
        check_eq("rst_pending_tc_a", 12'(tc_a), 12'h0);
        step_in = 1'b0;
        tick;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
